counter_load_seq: RTL and testbench
===================================

// Module: counter_load_seq
// PURPOSE
//  Upstream sequencer for the 3-bit load/count counter. Accepts a run request
//  (start value + wrap count) over a valid/ready handshake, drives a one-cycle
//  load, enables counting until the requested terminal count, then freezes the
//  counter at all-ones and pulses done. Sits between the test/control logic and
//  the counter; its outputs connect directly to the counter's ld_enb/data_in/count_enb.
// PARAMETERS
//  WIDTH   3  counter width; terminal count = all-ones (2**WIDTH-1)
//  WRAP_W  4  width of the wrap-count field
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  rst_n       in   1        synchronous reset, active-low
//  req_valid   in   1        run request valid
//  req_ready   out  1        sequencer can accept a request
//  req_start   in   WIDTH    value to load into the counter
//  req_wraps   in   WRAP_W   extra terminal counts to pass before stopping
//  abort       in   1        terminate current run early
//  count_out   in   WIDTH    counter output, fed back
//  ld_enb      out  1        counter load enable
//  data_in     out  WIDTH    counter load data
//  count_enb   out  1        counter count enable
//  busy        out  1        high in LOAD or RUN
//  done        out  1        one-cycle pulse at end of run
//  done_err    out  1        qualifies done: 1 = ended by abort
// BEHAVIOUR
//  - Reset (rst_n low at posedge): state=IDLE, wraps_left=0, start_q=0, err_q=0.
//    Outputs: req_ready=1, ld_enb=0, data_in=0, count_enb=0, busy=0, done=0,
//    done_err=0. Mid-run reset drops ld_enb/count_enb on the next posedge. The
//    counter holds its value; counter_load_seq never resets the counter.
//  - FSM states: IDLE, LOAD, RUN, DONE. Outputs are decoded from state;
//    count_enb also depends on count_out.
//  - IDLE: req_ready=1. On req_valid&&req_ready: latch start_q<=req_start,
//    wraps_left<=req_wraps, err_q<=0, go LOAD. abort in IDLE is ignored.
//  - LOAD (exactly 1 cycle): ld_enb=1, data_in=start_q, count_enb=0. Go RUN.
//  - RUN: tc = (count_out == all-ones); last = tc && (wraps_left==0).
//    count_enb = !last && !abort (combinational).
//    On tc && !last: wraps_left decrements by 1.
//    On last: go DONE. The counter is frozen at all-ones.
//  - DONE (1 cycle): done=1, done_err=err_q, req_ready=0. Go IDLE.
//  - abort in LOAD or RUN: ld_enb=0 and count_enb=0 in that same cycle; err_q<=1;
//    go DONE.
//  - abort and last in the same cycle: abort wins, done_err=1.
//  - ld_enb and count_enb are never high together.
//  - data_in=0 outside LOAD.
//  - busy = (state==LOAD || state==RUN). req_ready=0 in LOAD, RUN and DONE.
//    Requests in those states are not accepted; the requester must hold
//    req_valid.
//  - Latency, accept at cycle T0:
//    T1 = LOAD; counter = start at T2.
//    Number of RUN cycles = (2**WIDTH-1 - start) + 1 + wraps*2**WIDTH.
//    done occurs in the cycle after the last RUN cycle.
//  - Back-to-back: the next request can be accepted in the cycle after DONE.
// TESTING
//  1 rst_n=0 for 2 clks -> all outputs at reset values; req_ready=1; count_enb=0.
//  2 start=5, wraps=0 -> ld_enb for 1 cycle with data_in=5; count 5,6,7;
//    count_enb low while count=7; done=1, done_err=0 at T5; counter holds 7.
//  3 start=7, wraps=0 -> single RUN cycle with count_enb=0; done at T3;
//    count stays 7.
//  4 start=6, wraps=2 -> count 6,7,0..7,0..7; three tc events seen;
//    done after 18 RUN cycles; final count 7.
//  5 start=0, wraps=1, abort at the 4th RUN cycle -> count_enb=0 in that cycle;
//    done=1, done_err=1 in the next cycle; counter holds 3.
//  6 rst_n=0 mid-RUN (count=4) -> IDLE next clk; count_enb=0; no done pulse;
//    new request start=2 accepted and completes normally.

Source files
------------

// File: rtl/counter_load_seq.sv
// Run sequencer for the load/count counter: accepts a (start, wraps) request,
// issues a one-cycle load, counts to the final terminal count, then pulses done.
module counter_load_seq #(
   parameter int WIDTH  = 3,
   parameter int WRAP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [WIDTH-1:0]  req_start,
   input  logic [WRAP_W-1:0] req_wraps,
   input  logic              abort,
   input  logic [WIDTH-1:0]  count_out,
   output logic              ld_enb,
   output logic [WIDTH-1:0]  data_in,
   output logic              count_enb,
   output logic              busy,
   output logic              done,
   output logic              done_err
);

   // Handshake: a request transfers on any posedge where req_valid && req_ready;
   // the requester holds req_valid and its fields stable until that edge.
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t              state;
   logic [WRAP_W-1:0]   wraps_left;
   logic [WIDTH-1:0]    start_q;
   logic                err_q;
   logic                tc;
   logic                last;

   assign tc   = (count_out == {WIDTH{1'b1}});
   assign last = tc && (wraps_left == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wraps_left <= '0;
         start_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  start_q    <= req_start;
                  wraps_left <= req_wraps;
                  err_q      <= 1'b0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (abort) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               // abort outranks reaching the final terminal count
               if (abort) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else if (last) begin
                  state <= DONE;
               end else if (tc) begin
                  wraps_left <= wraps_left - WRAP_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state == LOAD) || (state == RUN);
   assign ld_enb    = (state == LOAD) && !abort;
   assign data_in   = (state == LOAD) ? start_q : '0;
   // Combinational so the counter freezes at all-ones in the final RUN cycle.
   assign count_enb = (state == RUN) && !last && !abort;
   assign done      = (state == DONE);
   assign done_err  = (state == DONE) && err_q;

endmodule

// File: tb/tb_counter_load_seq.sv
// Bench for counter_load_seq: drives requests into the sequencer, models the
// attached 3-bit counter, and scores each completed run against a run-level model.
module tb_counter_load_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_start;
   logic [3:0] req_wraps;
   logic       abort;
   logic [2:0] count_out;
   logic       ld_enb;
   logic [2:0] data_in;
   logic       count_enb;
   logic       busy;
   logic       done;
   logic       done_err;

   int n_checks = 0;
   int n_pass   = 0;
   int busy_cnt = 0;
   int model_cnt = 0;

   // Expected run outcome: {err[15], final count[14:12], busy cycles[11:3], start[2:0]}
   logic [15:0] exp_q[$];

   counter_load_seq #(.WIDTH(3), .WRAP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_start(req_start), .req_wraps(req_wraps), .abort(abort),
      .count_out(count_out), .ld_enb(ld_enb), .data_in(data_in),
      .count_enb(count_enb), .busy(busy), .done(done), .done_err(done_err)
   );

   // Clock/reset block
   always #5 clk = ~clk;

   // The external counter being sequenced; it has no reset of its own.
   initial count_out = 3'd0;
   always @(posedge clk) begin
      if (ld_enb)         count_out <= data_in;
      else if (count_enb) count_out <= count_out + 3'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Run-level reference: the counter walks start..7 once, then 8 more values
   // per wrap; abort at cycle k after accept cuts the run to k busy cycles.
   task automatic push_model(input logic [2:0] s, input logic [3:0] w, input int ab);
      int run_len, bc, cnt;
      logic err;
      run_len = (7 - int'(s)) + 1 + int'(w) * 8;
      if (ab >= 1 && ab <= run_len + 1) begin
         err = 1'b1;
         bc  = ab;
         cnt = (ab == 1) ? model_cnt : (int'(s) + ab - 2) % 8;
      end else begin
         err = 1'b0;
         bc  = run_len + 1;
         cnt = 7;
      end
      model_cnt = cnt;
      exp_q.push_back({err, 3'(cnt), 9'(bc), s});
   endtask

   // Driver: present a request, hold it until accepted, optionally pulse abort
   // ab cycles after acceptance (1 = the load cycle).
   task automatic run_req(input logic [2:0] s, input logic [3:0] w, input int ab, input bit scored);
      int n;
      if (scored) push_model(s, w, ab);
      @(negedge clk);
      req_valid = 1'b1;
      req_start = s;
      req_wraps = w;
      n = 0;
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n >= 400), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_start = 3'($urandom_range(0, 7));
      if (ab > 0) begin
         repeat (ab - 1) @(posedge clk);
         #1 abort = 1'b1;
         @(posedge clk);
         #1 abort = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy || done) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n >= 2000), 32'd0);
   endtask

   // Monitor/scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         chk("ld_count_exclusive", 32'(ld_enb && count_enb), 32'd0);
         chk("abort_gates_enables", 32'(abort && (ld_enb || count_enb)), 32'd0);
         chk("data_in_idle_zero", busy ? 32'd0 : 32'(data_in), 32'd0);
         if (busy) busy_cnt++;
         if (ld_enb && exp_q.size() > 0) chk("load_data", 32'(data_in), 32'(exp_q[0][2:0]));
         if (done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL done_unexpected: got done=1 expected no run pending at %0t", $time);
            end else begin
               logic [15:0] e;
               n_pass++;
               e = exp_q.pop_front();
               chk("done_err", 32'(done_err), 32'(e[15]));
               chk("final_count", 32'(count_out), 32'(e[14:12]));
               chk("busy_cycles", 32'(busy_cnt), 32'(e[11:3]));
               chk("ready_low_in_done", 32'(req_ready), 32'd0);
            end
            busy_cnt = 0;
         end
      end
   end

   initial begin
      int run_len, ab;
      logic [2:0] s;
      logic [3:0] w;
      rst_n = 1'b0; req_valid = 1'b0; req_start = 3'd0; req_wraps = 4'd0; abort = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_ld_enb", 32'(ld_enb), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_count_enb", 32'(count_enb), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_done_err", 32'(done_err), 32'd0);
      rst_n = 1'b1;

      // abort while idle has no effect
      @(negedge clk) abort = 1'b1;
      @(negedge clk);
      chk("idle_abort_busy", 32'(busy), 32'd0);
      chk("idle_abort_ready", 32'(req_ready), 32'd1);
      abort = 1'b0;

      run_req(3'd5, 4'd0, 0, 1'b1);
      drain();
      run_req(3'd7, 4'd0, 0, 1'b1);
      drain();
      run_req(3'd6, 4'd2, 0, 1'b1);
      drain();
      run_req(3'd0, 4'd1, 5, 1'b1);   // abort in the 4th RUN cycle
      drain();
      run_req(3'd3, 4'd1, 1, 1'b1);   // abort during LOAD
      drain();

      // Mid-run reset: counter sits at 4 with count_enb high, so it steps to 5.
      run_req(3'd0, 4'd0, 0, 1'b0);
      begin
         int n;
         n = 0;
         while (count_out != 3'd4 && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("reach_count4_timeout", 32'(n >= 50), 32'd0);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_count_enb", 32'(count_enb), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd1);
      chk("midrst_counter_held", 32'(count_out), 32'd5);
      model_cnt = 5;
      @(negedge clk) rst_n = 1'b1;
      run_req(3'd2, 4'd0, 0, 1'b1);
      drain();

      // Randomized back-to-back runs with occasional aborts
      for (int i = 0; i < 24; i++) begin
         s = 3'($urandom_range(0, 7));
         w = 4'($urandom_range(0, 3));
         run_len = (7 - int'(s)) + 1 + int'(w) * 8;
         ab = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, run_len + 1)) : 0;
         run_req(s, w, ab, 1'b1);
      end
      drain();
      repeat (3) @(negedge clk);
      chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
